// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and constants for the banked SRAM
package sram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    localparam int WM_WRITE_THROUGH = 0;
    localparam int WM_READ_FIRST    = 1;

    function automatic int byte_lanes(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/sram_bank.sv
// rtl/sram_bank.sv - one SRAM bank with byte-lane writes and a registered read port
module sram_bank
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 7,
    parameter int WRITE_MODE = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    we,
    input  logic                    clr,
    input  logic [DATA_WIDTH/8-1:0] bwe,
    input  logic [ADDR_BITS-1:0]    addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int LANES = byte_lanes(DATA_WIDTH);
    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] merged;

    always_comb begin
        merged = mem[addr];
        for (int i = 0; i < LANES; i++) begin
            if (bwe[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    // clr writes the (all-lane, zero) word without disturbing the read port
    always_ff @(posedge clk) begin
        if (clr || (en && we)) begin
            mem[addr] <= merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en) begin
            if (we && WRITE_MODE == WM_WRITE_THROUGH) begin
                rdata <= merged;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/sram_banked.sv
// rtl/sram_banked.sv - multi-bank single-port SRAM with clear engine and optional output stage
module sram_banked
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_BITS     = 7,
    parameter int NUM_BANKS     = 6,
    parameter int BANK_BITS     = 3,
    parameter int WRITE_MODE    = 0,
    parameter int OUT_REG       = 0,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cen,
    input  logic [BANK_BITS-1:0]    cen_c,
    input  logic                    wen,
    input  logic [DATA_WIDTH/8-1:0] bwen,
    input  logic [ADDR_BITS-1:0]    addr,
    input  logic [DATA_WIDTH-1:0]   data,
    output logic [DATA_WIDTH-1:0]   q,
    output logic                    q_valid,
    output logic                    init_busy,
    output logic                    sel_err
);

    state_t                 state;
    logic                   busy;
    logic [ADDR_BITS-1:0]   init_cnt;

    logic                   in_range;
    logic                   req;
    logic                   accept;
    logic                   bad_sel;

    logic [ADDR_BITS-1:0]    bank_addr;
    logic [DATA_WIDTH-1:0]   bank_wdata;
    logic [DATA_WIDTH/8-1:0] bank_bwe;
    logic [DATA_WIDTH-1:0]   bank_q [NUM_BANKS];

    logic [BANK_BITS-1:0]   sel_idx;
    logic                   valid_s;
    logic                   err_s;
    logic [DATA_WIDTH-1:0]  q_s;

    assign in_range = ({1'b0, cen_c} < (BANK_BITS + 1)'(NUM_BANKS));
    assign req      = !cen && !busy;
    assign accept   = req && in_range;
    assign bad_sel  = req && !in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= (INIT_ON_RESET != 0) ? ST_INIT : ST_IDLE;
            busy     <= (INIT_ON_RESET != 0);
            init_cnt <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (&init_cnt) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    busy <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign init_busy = busy;

    // While clearing, every bank is driven with the same zero write at init_cnt
    assign bank_addr  = busy ? init_cnt : addr;
    assign bank_wdata = busy ? '0 : data;
    assign bank_bwe   = busy ? '1 : ~bwen;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic en_b;
        assign en_b = accept && (cen_c == BANK_BITS'(b));

        sram_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_BITS  (ADDR_BITS),
            .WRITE_MODE (WRITE_MODE)
        ) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en_b),
            .we    (!wen),
            .clr   (busy),
            .bwe   (bank_bwe),
            .addr  (bank_addr),
            .wdata (bank_wdata),
            .rdata (bank_q[b])
        );
    end

    // sel_idx only moves on accepted accesses, so q holds between them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_idx <= '0;
            valid_s <= 1'b0;
            err_s   <= 1'b0;
        end else begin
            valid_s <= accept;
            err_s   <= bad_sel;
            if (accept) begin
                sel_idx <= cen_c;
            end
        end
    end

    always_comb begin
        q_s = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (sel_idx == BANK_BITS'(b)) begin
                q_s = bank_q[b];
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q       <= '0;
                q_valid <= 1'b0;
                sel_err <= 1'b0;
            end else begin
                q       <= q_s;
                q_valid <= valid_s;
                sel_err <= err_s;
            end
        end
    end else begin : g_out_comb
        assign q       = q_s;
        assign q_valid = valid_s;
        assign sel_err = err_s;
    end

endmodule

// File: doc/sram_banked.md
# sram_banked

Parametrised, multi-bank synchronous single-port SRAM used as the next-generation storage block in the lab datapath. It extends the single-array SRAM with bank selection through `cen_c`, per-byte write masking, and a selectable write mode (write-through or read-first). It also adds an optional output pipeline register and a post-reset clear engine, which zeroes every word before accesses are accepted.

## Interface
Parameters:
- DATA_WIDTH, 8, word width; must be a multiple of 8.
- ADDR_BITS, 7, address lines per bank (depth 2^ADDR_BITS).
- NUM_BANKS, 6, number of banks; must be ≤ 2^BANK_BITS.
- BANK_BITS, 3, width of `cen_c`.
- WRITE_MODE, 0, 0 = write-through (q shows new data), 1 = read-first (q shows old data).
- OUT_REG, 0, 1 adds one output register stage.
- INIT_ON_RESET, 1, 1 = clear all banks after reset.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cen  in  1  chip enable, active-low.
- cen_c  in  BANK_BITS  bank select.
- wen  in  1  write enable, active-low (0 = write, 1 = read).
- bwen  in  DATA_WIDTH/8  per-byte write enable, active-low; bit i covers data[8i+7:8i].
- addr  in  ADDR_BITS  word address within the bank.
- data  in  DATA_WIDTH  write data.
- q  out  DATA_WIDTH  read/write-through data.
- q_valid  out  1  q updated by an accepted access this cycle.
- init_busy  out  1  clear engine running; accesses are ignored.
- sel_err  out  1  one-cycle pulse when an access addresses a bank ≥ NUM_BANKS.

## Operation
- **Access acceptance.** An access is accepted at a rising edge when `cen`=0, `init_busy`=0 and `cen_c` < NUM_BANKS.
- **Write** (`wen`=0): lanes with `bwen[i]`=0 are written to bank `cen_c` at `addr`; the other lanes keep their stored value.
  - WRITE_MODE 0: q = merged new word.
  - WRITE_MODE 1: q = word before the write.
- **Read** (`wen`=1): q = stored word; `bwen` is ignored.
- **No accepted access:** q holds its value and `q_valid`=0.
- **Out-of-range bank:** `cen`=0 with `cen_c` ≥ NUM_BANKS and `init_busy`=0 means no array change, q holds, and `sel_err` pulses.
- **Bank isolation:** banks are independent; the same `addr` in different banks refers to distinct words.
- **FSM** (states ST_INIT, ST_IDLE):
  - Reset enters ST_INIT if INIT_ON_RESET=1, otherwise ST_IDLE.
  - ST_INIT: an internal counter 0..2^ADDR_BITS−1 writes zero to that address in all banks in parallel, one address per cycle. On terminal count it moves to ST_IDLE.
  - ST_IDLE is permanent until the next reset.
  - `init_busy` = (state == ST_INIT).
- **Simultaneous events:** an access presented while `init_busy`=1 is dropped silently, with no `sel_err` and no `q_valid`.
- **Reset mid-init:** restarts the clear from address 0.
- **Reset during normal operation:** the array is cleared again if INIT_ON_RESET=1. If INIT_ON_RESET=0, array contents are undefined after power-up and preserved across reset.

## Timing
- **Reset values:** q=0, q_valid=0, sel_err=0, init_busy=INIT_ON_RESET.
- **Latency:**
  - OUT_REG=0: q and q_valid are valid after the rising edge that accepts the access (1-cycle).
  - OUT_REG=1: one cycle later. sel_err is delayed identically.
- **Init duration:** `init_busy` is high for exactly 2^ADDR_BITS cycles after `rst_n` deasserts (128 cycles by default). The first access is accepted on the edge after `init_busy` falls.
- **Back-to-back:** one access per cycle with no bubbles. A read of an address on the cycle after writing it returns the new data.
- **Sampling:** inputs are sampled on the rising edge; driving them at the falling edge is the bench convention.

## Structure
- Package `sram_pkg`:
  - state enum (ST_INIT, ST_IDLE);
  - WRITE_MODE constants WM_WRITE_THROUGH=0, WM_READ_FIRST=1;
  - helper function for byte-lane count.
- Sub-module `sram_bank`: one array with per-byte write, sync read, and read-first/write-through select. Instantiate it NUM_BANKS times via generate.
- The top level holds the bank decode, init FSM/counter, output mux and the optional output register.

## Test plan
- **Write-through / readback:** defaults, bank 3. Write 8'h01,02,04,…,80 to addr 0..7, then read addr 0..7. q equals each written value one cycle after each access, and readback matches.
- **Bank isolation:** after the previous test, select `cen_c`=4 and read addr 0..7. q=8'h00 each time. Write 8'haa to bank 4 addr 0; bank 3 addr 0 still reads 8'h01.
- **Read-first:** WRITE_MODE=1. Write 8'haa to addr 0, then write 8'h55 to addr 0, then read addr 0. q = 8'h00, then 8'haa, then 8'h55.
- **Byte mask:** DATA_WIDTH=16. Write 16'h1234 with bwen=2'b00, then write 16'hABCD with bwen=2'b10. Readback is 16'h12CD.
- **Init and reset:**
  - After `rst_n` rises, `init_busy` stays high 128 cycles; a write during that window does not change the array.
  - Asserting `rst_n` low at cycle 60 of init restarts the 128-cycle count.
  - After init, every address reads 0.
- **Invalid bank and output register:** `cen_c`=6 read produces a `sel_err` pulse, q holds and `q_valid`=0. With OUT_REG=1, all q/q_valid responses shift by exactly one cycle.
